// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester id type and width defaults for the block-memory arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_BLOCK_W = 128;
  typedef logic [1:0] arbStateT;
  localparam arbStateT IDLE = 2'd0;
  localparam arbStateT BUSY = 2'd1;
  localparam arbStateT DONE = 2'd2;
  typedef logic reqIdT;
endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational two-way round-robin picker, the requester not granted last wins a tie
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic  valid0,
  input  logic  valid1,
  input  reqIdT lastGrant,
  output logic  grantValid,
  output reqIdT grantId
);
  // A lone requester wins outright; on a tie the grant alternates away from lastGrant
  always_comb begin
    grantValid = valid0 | valid1;
    grantId = (valid0 && valid1) ? ~lastGrant : reqIdT'(valid1);
  end
endmodule

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: shares one block memory between two cache controllers with round-robin fixed-latency accesses
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int MEM_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0Valid,
  input  logic               req0IsRead,
  input  logic [ADDR_W-1:0]  req0Address,
  input  logic [BLOCK_W-1:0] req0WriteData,
  output logic               req0Done,
  output logic [BLOCK_W-1:0] req0ReadData,
  input  logic               req1Valid,
  input  logic               req1IsRead,
  input  logic [ADDR_W-1:0]  req1Address,
  input  logic [BLOCK_W-1:0] req1WriteData,
  output logic               req1Done,
  output logic [BLOCK_W-1:0] req1ReadData,
  output logic               busy,
  output logic               memIsRead,
  output logic               memIsWrite,
  output logic [ADDR_W-1:0]  memAddress,
  output logic [BLOCK_W-1:0] memWriteData,
  input  logic [BLOCK_W-1:0] memReadData
);
  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  arbStateT state;
  logic [CNT_W-1:0] cnt;
  reqIdT lastGrant, gntId, pickId;
  logic pickValid, opRead;
  logic [ADDR_W-1:0] addrQ;
  logic [BLOCK_W-1:0] wdataQ, respData;
  mem_arb_rr_pick uPick (
    .valid0(req0Valid),
    .valid1(req1Valid),
    .lastGrant(lastGrant),
    .grantValid(pickValid),
    .grantId(pickId)
  );
  // Grant and latch a request in IDLE, count down the access in BUSY, then spend one cycle in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lastGrant <= 1'b1;
      gntId <= 1'b0;
      opRead <= 1'b0;
      addrQ <= '0;
      wdataQ <= '0;
      respData <= '0;
    end else begin
      case (state)
        IDLE: if (pickValid) begin
          gntId <= pickId;
          lastGrant <= pickId;
          opRead <= pickId ? req1IsRead : req0IsRead;
          addrQ <= pickId ? req1Address : req0Address;
          wdataQ <= pickId ? req1WriteData : req0WriteData;
          cnt <= CNT_W'(MEM_LATENCY - 1);
          state <= BUSY;
        end
        BUSY: if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          if (opRead) respData <= memReadData;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Outputs decode straight from the registered state, so an asynchronous reset clears them at once
  always_comb begin
    busy = state != IDLE;
    memIsRead = state == BUSY && opRead;
    memIsWrite = state == BUSY && !opRead && cnt == '0;
    memAddress = state == BUSY ? addrQ : '0;
    memWriteData = state == BUSY ? wdataQ : '0;
    req0Done = state == DONE && gntId == 1'b0;
    req1Done = state == DONE && gntId == 1'b1;
    req0ReadData = req0Done && opRead ? respData : '0;
    req1ReadData = req1Done && opRead ? respData : '0;
  end
endmodule

// File: doc/mem_arbiter_2p.md
# mem_arbiter_2p

Two-port block-memory arbiter and sequencer that shares one 128-bit-block memory between two cache controllers (e.g. an instruction cache and a data cache built like the 1a cache). Each requester presents a block read or block write with a valid/done handshake. The arbiter picks one requester round-robin, holds the memory signals stable for a fixed access latency, captures read data, and returns a one-cycle done pulse. It sits between the caches and the memory module in the multi-cache top level.

## Interface
- ADDR_W, 10: byte address width shared with caches and memory
- BLOCK_W, 128: block width (4 × 32-bit words)
- MEM_LATENCY, 4: memory access cycles, ≥1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0Valid / req1Valid  in  1  request pending; held until matching done
- req0IsRead / req1IsRead  in  1  1 = block read, 0 = block write
- req0Address / req1Address  in  ADDR_W  request address; held stable while valid
- req0WriteData / req1WriteData  in  BLOCK_W  block to write; held stable while valid
- req0Done / req1Done  out  1  one-cycle completion pulse
- req0ReadData / req1ReadData  out  BLOCK_W  block read data, valid while the matching done is high
- busy  out  1  high in BUSY and DONE
- memIsRead  out  1  memory read enable
- memIsWrite  out  1  memory write strobe, one cycle per write
- memAddress  out  ADDR_W  memory address
- memWriteData  out  BLOCK_W  memory write block
- memReadData  in  BLOCK_W  memory read block, combinational from memAddress

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, with at least one valid:
  - Pick the grantee. If only one requester is valid, it wins. If both are valid, the requester not granted last wins.
  - Latch grantee id, op, address and write data into internal registers.
  - Load cnt = MEM_LATENCY-1, update lastGrant, go to BUSY.
- IDLE, with no valid: stay in IDLE.
- BUSY:
  - memAddress, memWriteData and memIsRead come from the latched registers and stay stable for the whole state.
  - memIsWrite is high only in the cycle where cnt==0 and op is write.
  - If cnt!=0: decrement cnt.
  - If cnt==0: for a read, capture memReadData into respData; go to DONE.
- DONE: assert reqNDone for the latched grantee only. reqNReadData = respData for reads and 0 for writes. Go to IDLE.
- The inactive requester's done is 0 and its readData is 0. Requests arriving in BUSY or DONE wait.
- Requester rule: deassert valid, or present a new request, in the cycle after sampling done.
- lastGrant resets to 1, so requester 0 wins the first contention.
- No request is dropped. A requester that loses contention is guaranteed the next grant.

## Timing
- Every output resets to 0, asynchronously and immediately, including memIsWrite mid-write.
- Latency: valid sampled in IDLE at edge E. BUSY runs E+1 .. E+MEM_LATENCY. done is high in cycle E+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles, with an IDLE cycle between accesses.
- MEM_LATENCY=1: BUSY lasts one cycle; memIsWrite and the read capture happen in that same cycle.
- Reset asserted in BUSY aborts the access. If the reset comes before the strobe cycle, no write occurs. No done is issued, and the requester must re-request.
- memReadData is sampled only at the edge that ends the cnt==0 cycle of BUSY.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - ADDR_W and BLOCK_W defaults
  - a requester-id type (1 bit)
- Sub-module mem_arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: two valids and lastGrant.
  - Outputs: grantValid and grantId.
- The top level holds the FSM, the counter (width $clog2(MEM_LATENCY)+1) and the latch registers.

## Test plan
- Single read, MEM_LATENCY=4: req0 reads 0x040 while memory returns block 0xAAAA…; req0Done is high exactly 5 cycles after the sampling edge with that block. memIsRead is high for 4 cycles; memIsWrite stays 0.
- Single write: req1 writes 0x0DEADBEEF…01 to 0x3FC; memIsWrite is high for exactly one cycle (the 4th BUSY cycle) with that address and data; req1Done pulses with req1ReadData=0.
- Contention: both valid from reset; grant order is 0, 1, 0, 1 over 4 back-to-back requests; each done pulse goes to the correct port; each access takes 6 cycles.
- Starvation: req0 re-requests continuously while req1 is held; req1 is served by the second access.
- Reset in BUSY (2nd cycle of a write): all outputs drop to 0 immediately; memIsWrite never pulses; FSM is in IDLE after release; a fresh request completes normally.
- MEM_LATENCY=1: a read completes with done 2 cycles after the sampling edge, and data matches memory.
